multibyte_register: RTL

Parametrised byte-loaded register for address, instruction and jump values wider than the 8-bit datapath. It collects BYTES consecutive bytes from the 8-bit bus under a valid/ready handshake, MSB first, and flags when the value is complete. It also supports single-lane random writes and in-place increment with carry, so the same block serves as memory address register, program counter and jump target.

---
 rtl/multibyte_register_pkg.sv | 16 +
 rtl/multibyte_register_ptr.sv | 37 +++
 rtl/multibyte_register.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/multibyte_register_pkg.sv
// Shared types and helpers for the multibyte_register block.
package multibyte_register_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    READY = 1'b0,
    LOAD  = 1'b1
  } state_e;

  // Width of a lane index for a register of the given number of lanes.
  function automatic int ptr_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/multibyte_register_ptr.sv
// Loadable down-counter selecting the lane written by the next sequential byte.
module multibyte_register_ptr
  import multibyte_register_pkg::*;
#(
  parameter int BYTES = 2,
  parameter int PW    = ptr_width(BYTES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          dec_en,
  output logic [PW-1:0] ptr,
  output logic          terminal
);

  localparam logic [PW-1:0] C_TOP = PW'(BYTES - 1);
  localparam logic [PW-1:0] C_ONE = PW'(1);

  logic [PW-1:0] r_ptr;

  // Lane pointer: reload to the top lane, otherwise count down per accepted beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ptr <= C_TOP;
    end else if (load) begin
      r_ptr <= C_TOP;
    end else if (dec_en) begin
      r_ptr <= r_ptr - C_ONE;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign ptr      = r_ptr;
  assign terminal = (r_ptr == {PW{1'b0}});

endmodule

// File: rtl/multibyte_register.sv
// Byte-loaded wide register: MSB-first sequential load, lane writes, increment with carry.
// Define MULTIBYTE_REGISTER_DECR_EN to add the decr input and decrement-with-borrow.
module multibyte_register
  import multibyte_register_pkg::*;
#(
  parameter int BYTES    = 2,
  parameter int INC_STEP = 1,
  localparam int W       = BYTES * BYTE_W,
  localparam int PW      = ptr_width(BYTES)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic [BYTE_W-1:0]          byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  input  logic                       byte_wr,
  input  logic [$clog2(BYTES)-1:0]   byte_sel,
  input  logic                       incr,
`ifdef MULTIBYTE_REGISTER_DECR_EN
  input  logic                       decr,
`endif
  output logic [W-1:0]               value_out,
  output logic                       value_valid,
  output logic                       busy,
  output logic                       carry_out
);

  localparam logic [W:0] C_STEP = (W + 1)'(INC_STEP);

  state_e        r_state;
  state_e        w_state_next;
  logic [W-1:0]  r_value;
  logic [W-1:0]  w_value_arith;
  logic [W-1:0]  w_value_next;
  logic          r_valid;
  logic          w_valid_next;
  logic          r_busy;
  logic          r_carry;
  logic          w_carry_next;
  logic          w_ready;
  logic          w_accept;
  logic [PW-1:0] w_ptr;
  logic          w_terminal;
  logic          w_lane_we;
  logic [PW-1:0] w_lane_idx;
  logic          w_do_inc;
  logic          w_do_dec;
  logic [W:0]    w_sum;
  logic [W:0]    w_diff;

`ifdef MULTIBYTE_REGISTER_DECR_EN
  assign w_do_inc = incr && !decr;
  assign w_do_dec = decr && !incr;
`else
  assign w_do_inc = incr;
  assign w_do_dec = 1'b0;
`endif

  // Top bit of the widened sum/difference is the carry/borrow.
  assign w_sum    = {1'b0, r_value} + C_STEP;
  assign w_diff   = {1'b0, r_value} - C_STEP;

  assign w_ready  = (r_state == LOAD) && !load_start;
  assign w_accept = w_ready && byte_valid;

  multibyte_register_ptr #(
    .BYTES (BYTES),
    .PW    (PW)
  ) u_ptr (
    .clock    (clock),
    .reset    (reset),
    .load     (load_start),
    .dec_en   (w_accept && !w_terminal),
    .ptr      (w_ptr),
    .terminal (w_terminal)
  );

  // Next-state and operation select in priority order.
  always_comb begin
    w_state_next  = r_state;
    w_valid_next  = r_valid;
    w_carry_next  = 1'b0;
    w_value_arith = r_value;
    w_lane_we     = 1'b0;
    w_lane_idx    = w_ptr;
    if (load_start) begin
      w_state_next = LOAD;
      w_valid_next = 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (byte_valid) begin
            w_lane_we = 1'b1;
            if (w_terminal) begin
              w_state_next = READY;
              w_valid_next = 1'b1;
            end else begin
              w_state_next = LOAD;
            end
          end else begin
            w_state_next = LOAD;
          end
        end
        READY: begin
          if (byte_wr) begin
            w_lane_we  = (int'(byte_sel) < BYTES);
            w_lane_idx = PW'(byte_sel);
          end else if (w_do_inc) begin
            w_value_arith = w_sum[W-1:0];
            w_carry_next  = w_sum[W];
          end else if (w_do_dec) begin
            w_value_arith = w_diff[W-1:0];
            w_carry_next  = w_diff[W];
          end else begin
            w_value_arith = r_value;
          end
        end
        default: begin
          w_state_next = READY;
        end
      endcase
    end
  end

  // Merge the selected lane write into the next value.
  always_comb begin
    w_value_next = w_value_arith;
    for (int i = 0; i < BYTES; i++) begin
      if (w_lane_we && (int'(w_lane_idx) == i)) begin
        w_value_next[i*BYTE_W +: BYTE_W] = byte_in;
      end else begin
        w_value_next[i*BYTE_W +: BYTE_W] = w_value_arith[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= READY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered value and status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_value <= {W{1'b0}};
      r_valid <= 1'b1;
      r_busy  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_value <= w_value_next;
      r_valid <= w_valid_next;
      r_busy  <= (w_state_next == LOAD);
      r_carry <= w_carry_next;
    end
  end

  assign byte_ready  = w_ready;
  assign value_out   = r_value;
  assign value_valid = r_valid;
  assign busy        = r_busy;
  assign carry_out   = r_carry;

endmodule
